// File: rtl/branch_resolve_ctrl_if.sv
// Dispatch/execute-side interface of the branch resolution controller.
// master drives alloc and resolve requests; slave is the controller itself.
`ifndef GSH_PHT_SEL
`define GSH_PHT_SEL 10
`endif
`ifndef SPECTAG_LEN
`define SPECTAG_LEN 5
`endif

interface branch_resolve_ctrl_if #(
    parameter int PHT_SEL = `GSH_PHT_SEL,
    parameter int TAGS    = `SPECTAG_LEN
);
    logic               alloc_req;
    logic               alloc_ack;
    logic [TAGS-1:0]    alloc_tag;
    logic [TAGS-1:0]    spectagnow;
    logic [TAGS-1:0]    mpft_valid;
    logic [2:0]         brcnt;

    logic               ex_valid;
    logic [TAGS-1:0]    ex_tag;
    logic               ex_pred;
    logic               ex_taken;
    logic [PHT_SEL-1:0] ex_pht_idx;

    logic               prmiss;
    logic               prsuccess;
    logic [TAGS-1:0]    prtag;
    logic               we;
    logic               wcond;
    logic [PHT_SEL-1:0] went;
    logic               stale_err;

    modport master (
        output alloc_req, ex_valid, ex_tag, ex_pred, ex_taken, ex_pht_idx,
        input  alloc_ack, alloc_tag, spectagnow, mpft_valid, brcnt,
               prmiss, prsuccess, prtag, we, wcond, went, stale_err
    );

    modport slave (
        input  alloc_req, ex_valid, ex_tag, ex_pred, ex_taken, ex_pht_idx,
        output alloc_ack, alloc_tag, spectagnow, mpft_valid, brcnt,
               prmiss, prsuccess, prtag, we, wcond, went, stale_err
    );
endinterface

// File: rtl/branch_resolve_ctrl.sv
// Speculative-tag allocator and branch resolver: hands out one-hot tags in
// circular order, retires them on success, squashes younger tags on a miss.
`ifndef GSH_PHT_SEL
`define GSH_PHT_SEL 10
`endif
`ifndef SPECTAG_LEN
`define SPECTAG_LEN 5
`endif

module branch_resolve_ctrl #(
    parameter int PHT_SEL = `GSH_PHT_SEL,
    parameter int TAGS    = `SPECTAG_LEN
) (
    input  logic clk,
    input  logic reset,
    branch_resolve_ctrl_if.slave bus
);
    typedef logic [TAGS-1:0] tag_t;

    tag_t               spectag_q, spectag_d;
    tag_t               mpft_q, mpft_d;
    logic [2:0]         brcnt_q, brcnt_d;
    logic               prmiss_q, prmiss_d;
    logic               prsuccess_q, prsuccess_d;
    tag_t               prtag_q, prtag_d;
    logic               we_q, we_d;
    logic               wcond_q, wcond_d;
    logic [PHT_SEL-1:0] went_q, went_d;
    logic               stale_q, stale_d;

    logic full;
    logic accepted;
    logic is_miss;
    logic is_success;
    logic alloc_ack;
    tag_t younger;
    tag_t older;

    assign full       = (brcnt_q == 3'(TAGS));
    assign accepted   = bus.ex_valid & $onehot(bus.ex_tag) & (|(bus.ex_tag & mpft_q));
    assign is_miss    = accepted & (bus.ex_pred ^ bus.ex_taken);
    assign is_success = accepted & ~(bus.ex_pred ^ bus.ex_taken);
    // Free slots are only visible on the pre-update count; a miss blocks dispatch.
    assign alloc_ack  = bus.alloc_req & ~full & ~is_miss & ~reset;

    // Younger tags: walk circularly from ex_tag+1 until reaching the allocation pointer.
    always_comb begin
        int  ex_idx;
        int  spec_idx;
        int  pos;
        logic walking;
        // NOTE: every comb output gets a default first so no path can infer a latch.
        younger  = '0;
        ex_idx   = 0;
        spec_idx = 0;
        walking  = 1'b1;
        for (int i = 0; i < TAGS; i++) begin
            if (bus.ex_tag[i])  ex_idx   = i;
            if (spectag_q[i])   spec_idx = i;
        end
        for (int k = 1; k < TAGS; k++) begin
            pos = (ex_idx + k) % TAGS;
            if (pos == spec_idx) walking = 1'b0;
            if (walking) younger[pos] = 1'b1;
        end
    end

    assign older = mpft_q & ~bus.ex_tag & ~younger;

    always_comb begin
        spectag_d   = spectag_q;
        mpft_d      = mpft_q;
        brcnt_d     = brcnt_q + 3'(alloc_ack) - 3'(is_success);
        prmiss_d    = 1'b0;
        prsuccess_d = 1'b0;
        prtag_d     = '0;
        we_d        = 1'b0;
        wcond_d     = 1'b0;
        went_d      = '0;
        stale_d     = stale_q;

        if (alloc_ack) begin
            mpft_d    = mpft_d | spectag_q;
            spectag_d = {spectag_q[TAGS-2:0], spectag_q[TAGS-1]};
        end
        if (is_success) begin
            mpft_d = mpft_d & ~bus.ex_tag;
        end
        if (is_miss) begin
            mpft_d    = older;
            spectag_d = bus.ex_tag;
            brcnt_d   = 3'($countones(older));
        end
        if (accepted) begin
            prmiss_d    = is_miss;
            prsuccess_d = is_success;
            prtag_d     = bus.ex_tag;
            we_d        = 1'b1;
            wcond_d     = bus.ex_taken;
            went_d      = bus.ex_pht_idx;
        end else if (bus.ex_valid) begin
            stale_d = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            spectag_q   <= tag_t'(1);
            mpft_q      <= '0;
            brcnt_q     <= '0;
            prmiss_q    <= 1'b0;
            prsuccess_q <= 1'b0;
            prtag_q     <= '0;
            we_q        <= 1'b0;
            wcond_q     <= 1'b0;
            went_q      <= '0;
            stale_q     <= 1'b0;
        end else begin
            spectag_q   <= spectag_d;
            mpft_q      <= mpft_d;
            brcnt_q     <= brcnt_d;
            prmiss_q    <= prmiss_d;
            prsuccess_q <= prsuccess_d;
            prtag_q     <= prtag_d;
            we_q        <= we_d;
            wcond_q     <= wcond_d;
            went_q      <= went_d;
            stale_q     <= stale_d;
        end
    end

    assign bus.alloc_ack  = alloc_ack;
    assign bus.alloc_tag  = spectag_q;
    assign bus.spectagnow = spectag_q;
    assign bus.mpft_valid = mpft_q;
    assign bus.brcnt      = brcnt_q;
    assign bus.prmiss     = prmiss_q;
    assign bus.prsuccess  = prsuccess_q;
    assign bus.prtag      = prtag_q;
    assign bus.we         = we_q;
    assign bus.wcond      = wcond_q;
    assign bus.went       = went_q;
    assign bus.stale_err  = stale_q;
endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Directed bench for branch_resolve_ctrl: allocation order, success, miss
// squash, full/alloc interplay, rejected resolutions and reset override.
module tb_branch_resolve_ctrl;
    localparam int PHT_SEL = 10;
    localparam int TAGS    = 5;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_pass   = 0;

    branch_resolve_ctrl_if #(.PHT_SEL(PHT_SEL), .TAGS(TAGS)) bus ();

    branch_resolve_ctrl #(.PHT_SEL(PHT_SEL), .TAGS(TAGS)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ex(input logic v, input logic [4:0] t, input logic p,
                          input logic tk, input logic [9:0] idx);
        bus.ex_valid   = v;
        bus.ex_tag     = t;
        bus.ex_pred    = p;
        bus.ex_taken   = tk;
        bus.ex_pht_idx = idx;
    endtask

    task automatic idle();
        bus.alloc_req = 1'b0;
        set_ex(1'b0, 5'b0, 1'b0, 1'b0, 10'h0);
    endtask

    task automatic check_state(input string tag, input logic [4:0] mpft,
                               input logic [4:0] spec, input logic [2:0] cnt);
        check({tag, ".mpft"},  32'(bus.mpft_valid), 32'(mpft));
        check({tag, ".spec"},  32'(bus.spectagnow), 32'(spec));
        check({tag, ".brcnt"}, 32'(bus.brcnt),      32'(cnt));
    endtask

    task automatic check_pulses(input string tag, input logic miss, input logic succ,
                                input logic [4:0] ptag, input logic w, input logic wc,
                                input logic [9:0] widx);
        check({tag, ".prmiss"},    32'(bus.prmiss),    32'(miss));
        check({tag, ".prsuccess"}, 32'(bus.prsuccess), 32'(succ));
        check({tag, ".prtag"},     32'(bus.prtag),     32'(ptag));
        check({tag, ".we"},        32'(bus.we),        32'(w));
        check({tag, ".wcond"},     32'(bus.wcond),     32'(wc));
        check({tag, ".went"},      32'(bus.went),      32'(widx));
    endtask

    task automatic alloc_one(input string tag, input logic [4:0] exp_tag);
        bus.alloc_req = 1'b1;
        #1;
        check({tag, ".ack"}, 32'(bus.alloc_ack), 32'd1);
        check({tag, ".tag"}, 32'(bus.alloc_tag), 32'(exp_tag));
        tick();
        bus.alloc_req = 1'b0;
    endtask

    initial begin
        idle();
        reset = 1'b1;
        bus.alloc_req = 1'b1;
        tick();
        check("rst.ack_held", 32'(bus.alloc_ack), 32'd0);
        tick();
        check_state("rst", 5'b00000, 5'b00001, 3'd0);
        check_pulses("rst", 1'b0, 1'b0, 5'b0, 1'b0, 1'b0, 10'h0);
        check("rst.stale", 32'(bus.stale_err), 32'd0);

        // Six back-to-back requests: five grants in circular order, then full.
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            bus.alloc_req = 1'b1;
            #1;
            check($sformatf("fill%0d.ack", i), 32'(bus.alloc_ack), (i < 5) ? 32'd1 : 32'd0);
            if (i < 5) check($sformatf("fill%0d.tag", i), 32'(bus.alloc_tag), 32'(1) << i);
            tick();
        end
        idle();
        check_state("fill", 5'b11111, 5'b00001, 3'd5);

        // Reset overrides a same-cycle alloc and an otherwise valid miss.
        reset = 1'b1;
        bus.alloc_req = 1'b1;
        set_ex(1'b1, 5'b00001, 1'b0, 1'b1, 10'h3FF);
        #1;
        check("rstmid.ack", 32'(bus.alloc_ack), 32'd0);
        tick();
        check_state("rstmid", 5'b00000, 5'b00001, 3'd0);
        check_pulses("rstmid", 1'b0, 1'b0, 5'b0, 1'b0, 1'b0, 10'h0);
        reset = 1'b0;
        idle();

        // Success on the oldest of two outstanding tags.
        alloc_one("a0", 5'b00001);
        alloc_one("a1", 5'b00010);
        set_ex(1'b1, 5'b00001, 1'b1, 1'b1, 10'h02A);
        tick();
        idle();
        check_pulses("succ1", 1'b0, 1'b1, 5'b00001, 1'b1, 1'b1, 10'h02A);
        check_state("succ1", 5'b00010, 5'b00100, 3'd1);
        set_ex(1'b1, 5'b00010, 1'b0, 1'b0, 10'h005);
        tick();
        idle();
        check_pulses("succ2", 1'b0, 1'b1, 5'b00010, 1'b1, 1'b0, 10'h005);
        check_state("succ2", 5'b00000, 5'b00100, 3'd0);
        tick();
        check_pulses("quiet", 1'b0, 1'b0, 5'b0, 1'b0, 1'b0, 10'h0);

        // Fill starting at 00100, then free the oldest while requesting.
        alloc_one("b0", 5'b00100);
        alloc_one("b1", 5'b01000);
        alloc_one("b2", 5'b10000);
        alloc_one("b3", 5'b00001);
        alloc_one("b4", 5'b00010);
        check_state("full2", 5'b11111, 5'b00100, 3'd5);
        bus.alloc_req = 1'b1;
        set_ex(1'b1, 5'b00100, 1'b0, 1'b0, 10'h111);
        #1;
        check("freeslot.ack", 32'(bus.alloc_ack), 32'd0);
        tick();
        idle();
        check_pulses("freeslot", 1'b0, 1'b1, 5'b00100, 1'b1, 1'b0, 10'h111);
        check_state("freeslot", 5'b11011, 5'b00100, 3'd4);
        alloc_one("reuse", 5'b00100);
        check_state("reuse", 5'b11111, 5'b01000, 3'd5);

        // Order is now 01000,10000,00001,00010,00100; miss on 10000 with a
        // competing alloc request squashes everything younger.
        bus.alloc_req = 1'b1;
        set_ex(1'b1, 5'b10000, 1'b1, 1'b0, 10'h2C3);
        #1;
        check("miss.ack", 32'(bus.alloc_ack), 32'd0);
        tick();
        idle();
        check_pulses("miss", 1'b1, 1'b0, 5'b10000, 1'b1, 1'b0, 10'h2C3);
        check_state("miss", 5'b01000, 5'b10000, 3'd1);
        alloc_one("postmiss", 5'b10000);
        check_state("postmiss", 5'b11000, 5'b00001, 3'd2);

        // Rejected resolutions: non-one-hot tag, then a tag not outstanding.
        set_ex(1'b1, 5'b00011, 1'b0, 1'b1, 10'h077);
        tick();
        idle();
        check_pulses("bad_oh", 1'b0, 1'b0, 5'b0, 1'b0, 1'b0, 10'h0);
        check_state("bad_oh", 5'b11000, 5'b00001, 3'd2);
        check("bad_oh.stale", 32'(bus.stale_err), 32'd1);
        set_ex(1'b1, 5'b00100, 1'b1, 1'b1, 10'h078);
        tick();
        idle();
        check_pulses("bad_nv", 1'b0, 1'b0, 5'b0, 1'b0, 1'b0, 10'h0);
        check_state("bad_nv", 5'b11000, 5'b00001, 3'd2);
        tick();
        check("stale.sticky", 32'(bus.stale_err), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("stale.cleared", 32'(bus.stale_err), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end
endmodule

// File: doc/branch_resolve_ctrl.md
BRANCH_RESOLVE_CTRL -- requirements
Module: branch_resolve_ctrl

Interface
- REQ-001: Parameter PHT_SEL, default `GSH_PHT_SEL, sets the PHT index width.
- REQ-002: Parameter TAGS, default `SPECTAG_LEN (5), sets the number of one-hot speculative tags; only 5 is supported.
- REQ-003: clk  in  1  clock; all state on posedge.
- REQ-004: reset  in  1  reset, synchronous, active-high; clock clk.
- REQ-005: alloc_req  in  1  dispatch requests a tag for a new conditional branch.
- REQ-006: alloc_ack  out  1  combinational; tag granted this cycle.
- REQ-007: alloc_tag  out  5  combinational one-hot tag granted (equals spectagnow).
- REQ-008: spectagnow  out  5  registered one-hot allocation pointer.
- REQ-009: mpft_valid  out  5  registered; bit i set means tag i is outstanding (unresolved).
- REQ-010: brcnt  out  3  registered outstanding count, 0..5.
- REQ-011: ex_valid  in  1  a branch resolves this cycle.
- REQ-012: ex_tag  in  5  one-hot tag of the resolving branch.
- REQ-013: ex_pred  in  1  predicted direction carried with the branch.
- REQ-014: ex_taken  in  1  actual direction.
- REQ-015: ex_pht_idx  in  PHT_SEL  PHT index the branch used at fetch.
- REQ-016: prmiss, prsuccess  out  1 each  registered one-cycle pulses.
- REQ-017: prtag  out  5  registered; tag of the resolved branch.
- REQ-018: we, wcond  out  1 each  registered PHT update strobe and direction.
- REQ-019: went  out  PHT_SEL  registered PHT update index.
- REQ-020: stale_err  out  1  registered sticky error flag.

Function
- REQ-021: Tag order: 00001 -> 00010 -> 00100 -> 01000 -> 10000 -> 00001 (wrap).
- REQ-022: full = (brcnt == 5).
- REQ-023: alloc_ack = alloc_req & ~full & ~(ex_valid & accepted miss).
- REQ-024: On alloc_ack, set mpft_valid[spectagnow], rotate spectagnow one position, and increment brcnt.
- REQ-025: A resolution is accepted iff ex_valid, ex_tag is exactly one-hot, and (ex_tag & mpft_valid) != 0.
- REQ-026: An accepted resolution with ex_pred == ex_taken is a success: clear the ex_tag bit and decrement brcnt; next cycle prsuccess=1, prtag=ex_tag.
- REQ-027: An accepted resolution with ex_pred != ex_taken is a miss: clear the ex_tag bit and every younger bit; set spectagnow to ex_tag; set brcnt to the number of older outstanding tags; next cycle prmiss=1, prtag=ex_tag.
- REQ-028: Younger tags are those from ex_tag+1 up to spectagnow-1, walking circularly in REQ-021 order.
- REQ-029: Every accepted resolution produces, next cycle, we=1, wcond=ex_taken, went=ex_pht_idx.
- REQ-030: prmiss and prsuccess are never both 1.
- REQ-031: All registered outputs other than mpft_valid, spectagnow, brcnt, and stale_err are 0 in any cycle with no accepted resolution in the previous cycle.
- REQ-032: When ex_valid=1 and the resolution is not accepted: no state change and no output pulse; stale_err is set until reset.
- REQ-033: Simultaneous success and alloc: both are applied in the same cycle; alloc_ack is evaluated on pre-update full, so a slot freed this cycle is not grantable this cycle.
- REQ-034: Simultaneous miss and alloc: the miss wins and alloc_ack=0.

Reset
- REQ-035: On reset: spectagnow=00001, mpft_valid=0, brcnt=0, prmiss=prsuccess=0, prtag=0, we=wcond=0, went=0, stale_err=0.
- REQ-036: Reset asserted mid-operation overrides any same-cycle alloc or resolve; alloc_ack=0 while reset=1.

Verification
- REQ-037: Reset, then alloc_req for 6 consecutive cycles -> acks on cycles 1-5 with tags 00001..10000; cycle 6 ack=0; brcnt=5; mpft_valid=11111; spectagnow=00001.
- REQ-038: Tags 00001,00010 outstanding; resolve ex_tag=00001, pred=taken=1, idx=0x2A -> next cycle prsuccess=1, prtag=00001, we=1, wcond=1, went=0x2A; mpft_valid=00010; brcnt=1.
- REQ-039: Tags 01000,10000,00001,00010 allocated in that order (wrapped); miss on 10000 -> mpft_valid=01000, spectagnow=10000, brcnt=1, next cycle prmiss=1, prtag=10000.
- REQ-040: Full (brcnt=5); same cycle success on 00100 plus alloc_req -> alloc_ack=0 that cycle; next cycle alloc_req -> ack with alloc_tag=00100.
- REQ-041: Miss and alloc_req in the same cycle -> alloc_ack=0; no new tag set.
- REQ-042: ex_valid with ex_tag=00011, or with a non-outstanding tag -> no pulses, state unchanged, stale_err=1 until reset.
